// File: rtl/bip_control.sv
// BIP processor control unit: fetch/execute sequencer, program counter, instruction
// decode and a saturating retired-instruction counter with a start/halt handshake.
module bip_control #(
    parameter int len_addr   = 11,
    parameter int len_opcode = 5,
    parameter int len_mux_a  = 2,
    parameter int len_count  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [len_opcode+len_addr-1:0] instruction,
    output logic [len_addr-1:0]          pc,
    output logic [len_addr-1:0]          operand,
    output logic [len_mux_a-1:0]         SelA,
    output logic                         SelB,
    output logic                         WrAcc,
    output logic                         Op,
    output logic                         WrRam,
    output logic                         RdRam,
    output logic                         busy,
    output logic                         halted,
    output logic [len_count-1:0]         inst_count
);

    // state | meaning
    // IDLE  | after reset, pc=0, waiting for start
    // FETCH | pc presented, program memory reading
    // EXEC  | instruction word valid, decode strobes asserted
    // HALT  | HLT retired, pc holds at HLT address, waiting for start
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    localparam logic [len_opcode-1:0] OP_HLT  = len_opcode'(0);
    localparam logic [len_opcode-1:0] OP_STO  = len_opcode'(1);
    localparam logic [len_opcode-1:0] OP_LD   = len_opcode'(2);
    localparam logic [len_opcode-1:0] OP_LDI  = len_opcode'(3);
    localparam logic [len_opcode-1:0] OP_ADD  = len_opcode'(4);
    localparam logic [len_opcode-1:0] OP_ADDI = len_opcode'(5);
    localparam logic [len_opcode-1:0] OP_SUB  = len_opcode'(6);
    localparam logic [len_opcode-1:0] OP_SUBI = len_opcode'(7);

    localparam logic [len_mux_a-1:0] SEL_MEM = len_mux_a'(0);
    localparam logic [len_mux_a-1:0] SEL_IMM = len_mux_a'(1);
    localparam logic [len_mux_a-1:0] SEL_ALU = len_mux_a'(2);

    state_t                state;
    logic [len_opcode-1:0] opcode;

    assign opcode  = instruction[len_opcode+len_addr-1 -: len_opcode];
    assign operand = instruction[len_addr-1:0];
    assign busy    = (state == FETCH) || (state == EXEC);
    assign halted  = (state == HALT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= '0;
            inst_count <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state      <= FETCH;
                        pc         <= '0;
                        inst_count <= '0;
                    end
                end
                FETCH: state <= EXEC;
                EXEC: begin
                    if (inst_count != '1)
                        inst_count <= inst_count + len_count'(1);
                    if (opcode == OP_HLT) begin
                        state <= HALT;
                    end else begin
                        state <= FETCH;
                        pc    <= pc + len_addr'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are decoded straight from state so an async reset drops them at once.
    always_comb begin
        SelA  = SEL_MEM;
        SelB  = 1'b0;
        WrAcc = 1'b0;
        Op    = 1'b0;
        WrRam = 1'b0;
        RdRam = 1'b0;
        if (state == EXEC) begin
            case (opcode)
                OP_STO: WrRam = 1'b1;
                OP_LD: begin
                    RdRam = 1'b1;
                    WrAcc = 1'b1;
                end
                OP_LDI: begin
                    SelA  = SEL_IMM;
                    WrAcc = 1'b1;
                end
                OP_ADD: begin
                    RdRam = 1'b1;
                    SelA  = SEL_ALU;
                    WrAcc = 1'b1;
                end
                OP_ADDI: begin
                    SelB  = 1'b1;
                    SelA  = SEL_ALU;
                    WrAcc = 1'b1;
                end
                OP_SUB: begin
                    RdRam = 1'b1;
                    Op    = 1'b1;
                    SelA  = SEL_ALU;
                    WrAcc = 1'b1;
                end
                OP_SUBI: begin
                    SelB  = 1'b1;
                    Op    = 1'b1;
                    SelA  = SEL_ALU;
                    WrAcc = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bip_control.md
# bip_control

Control unit of the BIP processor. It sequences fetch and execute over the synchronous program memory, holds the program counter, and decodes each instruction word. It drives the accumulator-input select, the ALU operand select and opcode, and the data-memory read/write strobes, which together steer the accumulator path. A start/halt handshake and a retired-instruction counter let the host run and observe a program.

## Interface
Parameters:
- len_addr, 11, program-counter and operand-field width
- len_opcode, 5, opcode field width; instruction word is len_opcode + len_addr bits
- len_mux_a, 2, width of SelA
- len_count, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; low forces the reset state immediately
- start  in  1  one-cycle request to (re)start the program from address 0
- instruction  in  len_opcode+len_addr  program-memory output; valid in the cycle after pc is presented
- pc  out  len_addr  program-memory address
- operand  out  len_addr  instruction[len_addr-1:0], to sign extension and data-memory address
- SelA  out  len_mux_a  accumulator source: 00 data memory, 01 operand, 10 ALU result
- SelB  out  1  ALU B source: 0 data memory, 1 operand
- WrAcc  out  1  accumulator load enable
- Op  out  1  ALU operation: 0 add, 1 subtract
- WrRam  out  1  data-memory write strobe
- RdRam  out  1  data-memory read strobe
- busy  out  1  high in FETCH and EXEC
- halted  out  1  high in HALT
- inst_count  out  len_count  instructions retired since last start

## Operation
- Opcode field: instruction[MSBs].
  - 00000 HLT
  - 00001 STO: WrRam
  - 00010 LD: RdRam, SelA=00, WrAcc
  - 00011 LDI: SelA=01, WrAcc
  - 00100 ADD: RdRam, SelB=0, Op=0, SelA=10, WrAcc
  - 00101 ADDI: SelB=1, Op=0, SelA=10, WrAcc
  - 00110 SUB: RdRam, SelB=0, Op=1, SelA=10, WrAcc
  - 00111 SUBI: SelB=1, Op=1, SelA=10, WrAcc
  - Any other opcode is a NOP: no strobes, pc advances, counted as retired.
- States:
  - IDLE: pc=0, no strobes. start moves to FETCH.
  - FETCH: pc is stable and memory is reading. Always moves to EXEC next cycle.
  - EXEC: decode is valid and strobes are asserted for exactly this cycle. Non-HLT: pc <= pc+1, inst_count increments, next state FETCH. HLT: pc holds, inst_count increments, next state HALT.
  - HALT: no strobes, pc holds at the HLT address. start clears pc and inst_count and moves to FETCH.
- start is ignored in FETCH and EXEC.
- Strobes and SelA/SelB/Op are combinational from state and instruction. All are 0 outside EXEC.
- pc wraps from 2^len_addr-1 to 0 without error.
- inst_count saturates at all-ones; it does not wrap.
- operand passes instruction through unconditionally.

## Timing
- Reset values:
  - pc, inst_count, SelA, SelB, Op: 0
  - WrAcc, WrRam, RdRam: 0
  - busy=0, halted=0, state IDLE
- start high at edge n in IDLE: FETCH in cycle n+1, EXEC in n+2, first strobes in n+2.
- Each instruction takes 2 cycles. The k-th instruction (k from 0) executes in cycle n+2+2k.
- pc updates on the edge ending EXEC. The new value is presented throughout the following FETCH.
- Reset asserted mid-EXEC: strobes drop combinationally and no write completes on the next edge.
- After reset deasserts, the block returns to IDLE and requires a new start.

## Test plan
- Reset then start, program LDI 5; HLT: WrAcc=1 with SelA=01 and operand=5 in cycle 2. HALT is reached with halted=1, pc=1, inst_count=2.
- Program LD 3; ADD 4; STO 5; HLT: per-EXEC strobes are {RdRam,SelA=00,WrAcc}, {RdRam,SelB=0,Op=0,SelA=10,WrAcc}, {WrRam}, none. inst_count=4.
- SUBI 2 followed by opcode 11111: SUBI gives Op=1, SelB=1, SelA=10. Opcode 11111 gives all strobes 0 and pc still increments.
- Start pulsed during FETCH/EXEC has no effect. Start in HALT gives pc=0, inst_count=0, and FETCH on the next cycle.
- Preload a NOP-only program with len_addr=3: pc sequence 0..7,0 wraps with no halted assertion.
- Pull reset low during an EXEC of STO: WrRam falls within the same cycle, and pc, inst_count and outputs read 0 with state IDLE.
